// File: rtl/roic_deser_align_seq_if.sv
// Handshake bundle between the register map / deserializer and the alignment sequencer.
interface roic_deser_align_seq_if;
  logic        start;
  logic        abort;
  logic [11:0] align_done;
  logic        deser_reset;
  logic        dly_tap_ld;
  logic [4:0]  dly_tap_in;
  logic        align_start;
  logic        busy;
  logic        done;
  logic        fail;
  logic [11:0] fail_mask;
  logic [2:0]  retry_cnt;

  modport master (
    output start, abort, align_done,
    input  deser_reset, dly_tap_ld, dly_tap_in, align_start,
    input  busy, done, fail, fail_mask, retry_cnt
  );

  modport slave (
    input  start, abort, align_done,
    output deser_reset, dly_tap_ld, dly_tap_in, align_start,
    output busy, done, fail, fail_mask, retry_cnt
  );
endinterface

// File: rtl/roic_deser_align_seq.sv
// Deserializer reset / delay-tap load / word-alignment sequencer with timeout and retry.
// Optional feature: define ROIC_ALIGN_TAP_SWEEP_EN to advance the tap by TAP_STEP on each retry.
module roic_deser_align_seq #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [4:0]  TAP_INIT       = 5'd0,
  parameter logic [4:0]  TAP_STEP       = 5'd4
) (
  input  logic                        clk_20mhz,
  input  logic                        rst_n_20mhz,
  roic_deser_align_seq_if.slave       bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_TAP_LOAD, S_SETTLE, S_ALIGN, S_WAIT, S_DONE, S_FAIL
  } state_e;

`ifdef ROIC_ALIGN_TAP_SWEEP_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif

  localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RETRY_MAX    = 3'(MAX_RETRY);
  // Without sweep the tap only ever holds TAP_INIT, so a zero step keeps it there.
  localparam logic [4:0]  RETRY_STEP   = SWEEP_EN ? TAP_STEP : 5'd0;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  tap_q, tap_d;
  logic [2:0]  retry_q, retry_d;
  logic [11:0] mask_q, mask_d;
  logic        busy;
  logic        all_done;

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
  assign all_done = &bus.align_done;

  always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
    if (!rst_n_20mhz) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tap_q   <= TAP_INIT;
      retry_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
      retry_q <= retry_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    tap_d   = tap_q;
    retry_d = retry_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        cnt_d = '0;
        if (bus.start && !bus.abort) begin
          state_d = S_RESET;
          tap_d   = TAP_INIT;
          retry_d = '0;
          mask_d  = '0;
        end
      end
      S_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_TAP_LOAD;
          cnt_d   = '0;
        end
      end
      S_TAP_LOAD: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_ALIGN;
          cnt_d   = '0;
        end
      end
      S_ALIGN: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // Full alignment is checked first so it wins over a coincident timeout.
        if (all_done) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 3'd1;
            tap_d   = tap_q + RETRY_STEP;
            state_d = S_RESET;
          end else begin
            mask_d  = ~bus.align_done;
            state_d = S_FAIL;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (busy && bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign bus.deser_reset = (state_q == S_RESET);
  assign bus.dly_tap_ld  = (state_q == S_TAP_LOAD);
  assign bus.dly_tap_in  = tap_q;
  assign bus.align_start = (state_q == S_ALIGN);
  assign bus.busy        = busy;
  assign bus.done        = (state_q == S_DONE);
  assign bus.fail        = (state_q == S_FAIL);
  assign bus.fail_mask   = mask_q;
  assign bus.retry_cnt   = retry_q;

endmodule
